// File: rtl/dport_router_pkg.sv
// Shared definitions for the dport bus blocks: tag width, responder states,
// and an elaboration-time ceil(log2) helper.
package dport_router_pkg;

  localparam int unsigned TAG_W = 11;

  typedef enum logic {
    ERR_IDLE,
    ERR_ACK
  } err_state_t;

  function automatic int unsigned dport_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dport_router_if.sv
// dport master-side bus: LSU request/attribute signals and the response path.
interface dport_router_if;
  import dport_router_pkg::*;

  logic [31:0]      addr;
  logic [31:0]      data_wr;
  logic             rd;
  logic [3:0]       wr;
  logic             cacheable;
  logic             invalidate;
  logic             writeback;
  logic             flush;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      data_rd;
  logic             accept;
  logic             ack;
  logic             error;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
    input  data_rd, accept, ack, error, resp_tag
  );

  modport slave (
    input  addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
    output data_rd, accept, ack, error, resp_tag
  );

endinterface

// File: rtl/dport_router_err_resp.sv
// One-entry error responder for unmapped accesses: acks with error exactly one
// cycle after accepting, echoing the captured request tag.
module dport_err_resp
  import dport_router_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             ready_o,
  output logic             ack_o,
  output logic [TAG_W-1:0] tag_o
);

  err_state_t       state_q, state_d;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ERR_IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_i) tag_q <= tag_i;
    end
  end

  // The ack is never stalled, so the slot frees in its own ack cycle and a
  // new request can be taken back-to-back.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b1;
    ack_o   = 1'b0;
    unique case (state_q)
      ERR_IDLE: if (req_i) state_d = ERR_ACK;
      ERR_ACK: begin
        ack_o   = 1'b1;
        state_d = req_i ? ERR_ACK : ERR_IDLE;
      end
      default: state_d = ERR_IDLE;
    endcase
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/dport_router.sv
// N-way dport address router: region decode, target-switch hold while requests
// are outstanding, pending counter and response mux from the last-accepted target.
module dport_router
  import dport_router_pkg::*;
#(
  parameter int unsigned             NUM_PORTS       = 3,
  parameter logic [NUM_PORTS*32-1:0] PORT_BASE       = {32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_PORTS*32-1:0] PORT_SIZE       = {32'h1000_0000, 32'h1000_0000, 32'h0001_0000},
  parameter bit                      ERR_ON_UNMAPPED = 1'b1,
  parameter int unsigned             DEFAULT_PORT    = 1,
  parameter int unsigned             MAX_PENDING     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  dport_router_if.slave              mem,
  output logic [NUM_PORTS*32-1:0]    tgt_addr_o,
  output logic [NUM_PORTS*32-1:0]    tgt_data_wr_o,
  output logic [NUM_PORTS-1:0]       tgt_rd_o,
  output logic [NUM_PORTS*4-1:0]     tgt_wr_o,
  output logic [NUM_PORTS-1:0]       tgt_cacheable_o,
  output logic [NUM_PORTS-1:0]       tgt_invalidate_o,
  output logic [NUM_PORTS-1:0]       tgt_writeback_o,
  output logic [NUM_PORTS-1:0]       tgt_flush_o,
  output logic [NUM_PORTS*TAG_W-1:0] tgt_req_tag_o,
  input  logic [NUM_PORTS*32-1:0]    tgt_data_rd_i,
  input  logic [NUM_PORTS*TAG_W-1:0] tgt_resp_tag_i,
  input  logic [NUM_PORTS-1:0]       tgt_accept_i,
  input  logic [NUM_PORTS-1:0]       tgt_ack_i,
  input  logic [NUM_PORTS-1:0]       tgt_error_i
);

  localparam int unsigned       SEL_W     = dport_clog2(NUM_PORTS + 1);
  localparam int unsigned       PEND_W    = dport_clog2(MAX_PENDING) + 1;
  localparam logic [SEL_W-1:0]  SEL_ERR   = SEL_W'(NUM_PORTS);
  localparam logic [SEL_W-1:0]  SEL_MISS  = ERR_ON_UNMAPPED ? SEL_ERR : SEL_W'(DEFAULT_PORT);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

  logic [NUM_PORTS-1:0] hit_w;
  logic [SEL_W-1:0]     idx_w, sel_q;
  logic [PEND_W-1:0]    pend_q;
  logic                 request_w, hold_w, ready_w, take_w, found_w;
  logic                 err_ready_w, err_ack_w;
  logic [TAG_W-1:0]     err_tag_w;

  // 33-bit offset keeps the range test free of 32-bit wraparound.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_decode
    localparam logic [31:0] BASE = PORT_BASE[32*g +: 32];
    localparam logic [31:0] SIZE = PORT_SIZE[32*g +: 32];
    logic [32:0] offset_w;
    assign offset_w = {1'b0, mem.addr} - {1'b0, BASE};
    assign hit_w[g] = (SIZE != '0) && !offset_w[32] && (offset_w[31:0] < SIZE);
  end

  always_comb begin
    idx_w   = SEL_MISS;
    found_w = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (hit_w[i] && !found_w) begin
        idx_w   = SEL_W'(i);
        found_w = 1'b1;
      end
    end
  end

  assign request_w = mem.rd | (|mem.wr) | mem.flush | mem.invalidate | mem.writeback;
  assign hold_w    = ((pend_q != '0) && (idx_w != sel_q)) || (pend_q == PEND_FULL);

  always_comb begin
    ready_w          = (idx_w == SEL_ERR) ? err_ready_w : 1'b0;
    tgt_rd_o         = '0;
    tgt_wr_o         = '0;
    tgt_invalidate_o = '0;
    tgt_writeback_o  = '0;
    tgt_flush_o      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (idx_w == SEL_W'(i)) begin
        ready_w = tgt_accept_i[i];
        if (!hold_w) begin
          tgt_rd_o[i]         = mem.rd;
          tgt_wr_o[4*i +: 4]  = mem.wr;
          tgt_invalidate_o[i] = mem.invalidate;
          tgt_writeback_o[i]  = mem.writeback;
          tgt_flush_o[i]      = mem.flush;
        end
      end
    end
  end

  assign mem.accept      = !hold_w && ready_w;
  assign take_w          = request_w && mem.accept;
  assign tgt_addr_o      = {NUM_PORTS{mem.addr}};
  assign tgt_data_wr_o   = {NUM_PORTS{mem.data_wr}};
  assign tgt_cacheable_o = {NUM_PORTS{mem.cacheable}};
  assign tgt_req_tag_o   = {NUM_PORTS{mem.req_tag}};

  dport_err_resp u_err_resp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (take_w && (idx_w == SEL_ERR)),
    .tag_i   (mem.req_tag),
    .ready_o (err_ready_w),
    .ack_o   (err_ack_w),
    .tag_o   (err_tag_w)
  );

  // Responses follow the registered selection so a new decode cannot steal them.
  always_comb begin
    mem.ack      = 1'b0;
    mem.error    = 1'b0;
    mem.data_rd  = '0;
    mem.resp_tag = '0;
    if (sel_q == SEL_ERR) begin
      mem.ack      = err_ack_w;
      mem.error    = err_ack_w;
      mem.resp_tag = err_tag_w;
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        mem.ack      = tgt_ack_i[i];
        mem.error    = tgt_error_i[i];
        mem.data_rd  = tgt_data_rd_i[32*i +: 32];
        mem.resp_tag = tgt_resp_tag_i[TAG_W*i +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      sel_q  <= '0;
    end else begin
      if (take_w) sel_q <= idx_w;
      if (take_w && !mem.ack) pend_q <= pend_q + PEND_W'(1);
      else if (!take_w && mem.ack && (pend_q != '0)) pend_q <= pend_q - PEND_W'(1);
    end
  end

  ack_without_pending_a: assert property (
    @(posedge clk_i) disable iff (rst_i) mem.ack |-> (pend_q != '0)
  );

endmodule

// File: tb/tb_dport_router.sv
// Bench for dport_router: random traffic against a queue-based reference model,
// directed corner cases, and a default-port instance.
module tb_dport_router;
  import dport_router_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- instance A: error responder for unmapped ----------------
  dport_router_if bus_a ();
  logic [95:0] ta_addr, ta_wdata, ta_rdata;
  logic [2:0]  ta_rd, ta_cache, ta_inv, ta_wb, ta_flush, ta_acc, ta_ack, ta_err;
  logic [11:0] ta_wr;
  logic [32:0] ta_tag, ta_rtag;

  dport_router #(
    .NUM_PORTS       (3),
    .PORT_BASE       ({32'h8FFF_0000, 32'h8000_0000, 32'h0000_0000}),
    .PORT_SIZE       ({32'h0002_0000, 32'h1000_0000, 32'h0001_0000}),
    .ERR_ON_UNMAPPED (1'b1),
    .DEFAULT_PORT    (1),
    .MAX_PENDING     (16)
  ) u_dut_a (
    .clk_i (clk), .rst_i (rst), .mem (bus_a),
    .tgt_addr_o (ta_addr), .tgt_data_wr_o (ta_wdata), .tgt_rd_o (ta_rd), .tgt_wr_o (ta_wr),
    .tgt_cacheable_o (ta_cache), .tgt_invalidate_o (ta_inv), .tgt_writeback_o (ta_wb),
    .tgt_flush_o (ta_flush), .tgt_req_tag_o (ta_tag), .tgt_data_rd_i (ta_rdata),
    .tgt_resp_tag_i (ta_rtag), .tgt_accept_i (ta_acc), .tgt_ack_i (ta_ack), .tgt_error_i (ta_err)
  );

  // ---------------- instance B: unmapped -> port 1, port 2 disabled ----------------
  dport_router_if bus_b ();
  logic [95:0] tb_addr, tb_wdata, tb_rdata;
  logic [2:0]  tb_rd, tb_cache, tb_inv, tb_wb, tb_flush, tb_acc, tb_ack, tb_err;
  logic [11:0] tb_wr;
  logic [32:0] tb_tag, tb_rtag;

  dport_router #(
    .NUM_PORTS       (3),
    .PORT_BASE       ({32'h8FFF_0000, 32'h8000_0000, 32'h0000_0000}),
    .PORT_SIZE       ({32'h0000_0000, 32'h1000_0000, 32'h0001_0000}),
    .ERR_ON_UNMAPPED (1'b0),
    .DEFAULT_PORT    (1),
    .MAX_PENDING     (4)
  ) u_dut_b (
    .clk_i (clk), .rst_i (rst), .mem (bus_b),
    .tgt_addr_o (tb_addr), .tgt_data_wr_o (tb_wdata), .tgt_rd_o (tb_rd), .tgt_wr_o (tb_wr),
    .tgt_cacheable_o (tb_cache), .tgt_invalidate_o (tb_inv), .tgt_writeback_o (tb_wb),
    .tgt_flush_o (tb_flush), .tgt_req_tag_o (tb_tag), .tgt_data_rd_i (tb_rdata),
    .tgt_resp_tag_i (tb_rtag), .tgt_accept_i (tb_acc), .tgt_ack_i (tb_ack), .tgt_error_i (tb_err)
  );

  // ---------------- reference model for A ----------------
  typedef struct {
    int          port;
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    m_sel   = 0;
  bit    err_due = 1'b0;

  logic [31:0] s_addr, s_wdata, next_rdata;
  logic        s_rd, s_cache, s_inv, s_wb, s_flush, next_err;
  logic [3:0]  s_wr;
  logic [10:0] s_tag;
  logic [2:0]  s_acc;
  int          ack_mode;  // 0 never, 1 random, 2 whenever possible
  logic [31:0] addr_tab[10];

  // Region map of instance A as plain 64-bit ranges; index 3 = error responder.
  function automatic int m_decode(input logic [31:0] addr);
    longint a;
    longint base[3];
    longint size[3];
    a = {32'h0, addr};
    base[0] = 64'h0;           size[0] = 64'h1_0000;
    base[1] = 64'h8000_0000;   size[1] = 64'h1000_0000;
    base[2] = 64'h8FFF_0000;   size[2] = 64'h2_0000;
    for (int p = 0; p < 3; p++)
      if (size[p] != 0 && a >= base[p] && a < base[p] + size[p]) return p;
    return 3;
  endfunction

  task automatic set_idle();
    s_rd = 0; s_wr = '0; s_inv = 0; s_wb = 0; s_flush = 0;
  endtask

  task automatic set_read(input logic [31:0] a, input logic [10:0] t, input logic [2:0] acc);
    set_idle();
    s_addr = a; s_rd = 1; s_tag = t; s_acc = acc;
  endtask

  task automatic rand_req();
    int k;
    set_idle();
    k = $urandom_range(8);
    case (k)
      1, 2: s_rd = 1;
      3: s_wr = 4'($urandom_range(15, 1));
      4: s_flush = 1;
      5: s_inv = 1;
      6: s_wb = 1;
      default: ;
    endcase
    s_addr  = ($urandom_range(3) == 0) ? $urandom : addr_tab[$urandom_range(9)];
    s_wdata = $urandom;
    s_tag   = 11'($urandom);
    s_cache = 1'($urandom_range(1));
    for (int p = 0; p < 3; p++) s_acc[p] = ($urandom_range(3) != 0);
    next_rdata = $urandom;
    next_err   = ($urandom_range(7) == 0);
  endtask

  task automatic apply_idle_a();
    bus_a.rd = 0; bus_a.wr = '0; bus_a.invalidate = 0; bus_a.writeback = 0; bus_a.flush = 0;
    ta_ack = '0; ta_err = '0;
  endtask

  task automatic step_a();
    bit          slave_ack, hold, acc_e, req, exp_ack;
    int          idx, spur;
    logic [2:0]  e_rd, e_inv, e_wb, e_fl;
    logic [11:0] e_wr;
    resp_t       h, n;
    @(negedge clk);
    bus_a.addr = s_addr; bus_a.data_wr = s_wdata; bus_a.rd = s_rd; bus_a.wr = s_wr;
    bus_a.cacheable = s_cache; bus_a.invalidate = s_inv; bus_a.writeback = s_wb;
    bus_a.flush = s_flush; bus_a.req_tag = s_tag;
    ta_acc = s_acc; ta_ack = '0; ta_err = '0;
    for (int p = 0; p < 3; p++) begin
      ta_rdata[p*32 +: 32] = $urandom;
      ta_rtag[p*11 +: 11]  = 11'($urandom);
    end
    slave_ack = 0;
    if (exp_q.size() != 0 && exp_q[0].port != 3 &&
        (ack_mode == 2 || (ack_mode == 1 && $urandom_range(2) == 0))) begin
      h = exp_q[0];
      slave_ack = 1;
      ta_ack[h.port] = 1'b1;
      ta_err[h.port] = h.err;
      ta_rdata[h.port*32 +: 32] = h.data;
      ta_rtag[h.port*11 +: 11]  = h.tag;
    end
    if (ack_mode == 1 && $urandom_range(7) == 0) begin
      spur = $urandom_range(2);
      if (spur != m_sel) begin
        ta_ack[spur] = 1'b1;
        ta_err[spur] = 1'b1;
      end
    end
    #1;
    idx   = m_decode(s_addr);
    req   = s_rd || (s_wr != 0) || s_flush || s_inv || s_wb;
    hold  = (exp_q.size() != 0 && idx != m_sel) || exp_q.size() == 16;
    acc_e = !hold && (idx == 3 ? 1'b1 : s_acc[idx]);
    e_rd = '0; e_inv = '0; e_wb = '0; e_fl = '0; e_wr = '0;
    if (!hold && idx != 3) begin
      e_rd[idx] = s_rd; e_inv[idx] = s_inv; e_wb[idx] = s_wb; e_fl[idx] = s_flush;
      e_wr[idx*4 +: 4] = s_wr;
    end
    exp_ack = slave_ack || err_due;
    check_eq("accept", bus_a.accept, acc_e);
    check_eq("tgt_rd", ta_rd, e_rd);
    check_eq("tgt_wr", ta_wr, e_wr);
    check_eq("tgt_ops", {ta_flush, ta_inv, ta_wb}, {e_fl, e_inv, e_wb});
    check_eq("tgt_bcast", {ta_addr[95:64], ta_tag[32:22], ta_cache}, {s_addr, s_tag, {3{s_cache}}});
    check_eq("ack", bus_a.ack, exp_ack);
    if (exp_ack && exp_q.size() != 0) begin
      h = exp_q[0];
      check_eq("rdata", bus_a.data_rd, h.data);
      check_eq("resp_tag", bus_a.resp_tag, h.tag);
      check_eq("error", bus_a.error, h.err);
      void'(exp_q.pop_front());
    end
    err_due = 1'b0;
    if (req && acc_e) begin
      n.port = idx;
      n.tag  = s_tag;
      n.data = (idx == 3) ? 32'h0 : next_rdata;
      n.err  = (idx == 3) ? 1'b1 : next_err;
      exp_q.push_back(n);
      m_sel = idx;
      if (idx == 3) err_due = 1'b1;
    end
  endtask

  task automatic drain_a();
    set_idle();
    ack_mode = 2;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step_a();
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic b_cycle(input logic [31:0] a, input logic rd, input logic [10:0] t,
                         input logic [2:0] acc, input int ack_port, input int spur_port,
                         input logic [31:0] rdata, input logic [10:0] rtag);
    @(negedge clk);
    bus_b.addr = a; bus_b.rd = rd; bus_b.req_tag = t;
    tb_acc = acc; tb_ack = '0; tb_err = '0;
    tb_rdata = ~{3{rdata}}; tb_rtag = ~{3{rtag}};
    if (ack_port >= 0) begin
      tb_ack[ack_port] = 1'b1;
      tb_rdata[ack_port*32 +: 32] = rdata;
      tb_rtag[ack_port*11 +: 11]  = rtag;
    end
    if (spur_port >= 0) tb_ack[spur_port] = 1'b1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    addr_tab = '{32'h0000_0100, 32'h0000_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                 32'h8FFF_0000, 32'h9000_0000, 32'h9000_FFFF, 32'h9001_0000, 32'hFFFF_FFFF};
    s_addr = '0; s_wdata = '0; s_cache = 0; s_tag = '0; s_acc = '0;
    next_rdata = '0; next_err = 0; ack_mode = 0;
    set_idle();
    bus_a.addr = '0; bus_a.data_wr = '0; bus_a.cacheable = 0; bus_a.req_tag = '0;
    apply_idle_a();
    ta_acc = '0; ta_rdata = '0; ta_rtag = '0;
    bus_b.addr = '0; bus_b.data_wr = '0; bus_b.rd = 0; bus_b.wr = '0; bus_b.cacheable = 0;
    bus_b.invalidate = 0; bus_b.writeback = 0; bus_b.flush = 0; bus_b.req_tag = '0;
    tb_acc = '0; tb_ack = '0; tb_err = '0; tb_rdata = '0; tb_rtag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, then a port-0 read acked two cycles later.
    step_a();
    set_read(32'h0000_0100, 11'h2A5, 3'b001);
    next_rdata = 32'hDEAD_BEEF; next_err = 0;
    step_a();
    set_idle(); step_a();
    ack_mode = 2; step_a();
    ack_mode = 0;
    set_read(32'h8000_0000, 11'h011, 3'b010); step_a();
    drain_a();

    // Target switch is held until the outstanding port-0 read completes.
    ack_mode = 0;
    set_read(32'h0000_0200, 11'h100, 3'b011); step_a();
    set_read(32'h8000_0000, 11'h101, 3'b011); step_a(); step_a();
    ack_mode = 2; step_a();
    ack_mode = 0; step_a();
    drain_a();

    // Fill to MAX_PENDING, hold, then ack alongside new requests.
    ack_mode = 0;
    for (int i = 0; i < 17; i++) begin
      set_read(32'h0000_0300 + 32'(i * 4), 11'(i), 3'b001);
      next_rdata = $urandom;
      step_a();
    end
    ack_mode = 2;
    for (int i = 0; i < 3; i++) begin
      set_read(32'h0000_0400, 11'(32 + i), 3'b001);
      step_a();
    end
    ack_mode = 0; step_a(); step_a();
    drain_a();

    // Unmapped accesses go to the error responder, back-to-back.
    ack_mode = 0;
    set_read(32'hF000_0000, 11'h055, 3'b111); step_a();
    set_read(32'hFFFF_FFFF, 11'h056, 3'b111); step_a();
    set_idle(); step_a();
    drain_a();

    // Reset with three reads outstanding drops all state.
    ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      set_read(32'h8000_0010, 11'(64 + i), 3'b010);
      step_a();
    end
    @(negedge clk);
    rst = 1'b1;
    apply_idle_a();
    set_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); m_sel = 0; err_due = 1'b0;
    set_read(32'h9000_0000, 11'h077, 3'b100); step_a();
    drain_a();

    // Randomized traffic.
    ack_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      rand_req();
      step_a();
    end
    drain_a();
    @(negedge clk);
    apply_idle_a();

    // Instance B: unmapped and disabled-region addresses fall through to port 1.
    b_cycle(32'hF000_0000, 1, 11'h123, 3'b010, -1, -1, 32'h0, 11'h0);
    check_eq("b_accept_dflt", bus_b.accept, 1'b1);
    check_eq("b_rd_dflt", tb_rd, 3'b010);
    check_eq("b_ack_idle", bus_b.ack, 1'b0);
    b_cycle(32'hF000_0000, 0, 11'h0, 3'b010, 1, -1, 32'hDEAD_BEEF, 11'h123);
    check_eq("b_ack_p1", bus_b.ack, 1'b1);
    check_eq("b_data_p1", bus_b.data_rd, 32'hDEAD_BEEF);
    check_eq("b_tag_p1", bus_b.resp_tag, 11'h123);
    check_eq("b_err_p1", bus_b.error, 1'b0);
    b_cycle(32'h9000_0000, 1, 11'h007, 3'b100, -1, -1, 32'h0, 11'h0);
    check_eq("b_accept_disabled", bus_b.accept, 1'b0);
    check_eq("b_rd_disabled", tb_rd, 3'b010);
    b_cycle(32'h0000_0000, 1, 11'h008, 3'b001, -1, -1, 32'h0, 11'h0);
    check_eq("b_accept_p0", bus_b.accept, 1'b1);
    check_eq("b_rd_p0", tb_rd, 3'b001);
    b_cycle(32'h0000_0000, 0, 11'h0, 3'b001, 0, 1, 32'hCAFE_F00D, 11'h008);
    check_eq("b_ack_p0", bus_b.ack, 1'b1);
    check_eq("b_data_p0", bus_b.data_rd, 32'hCAFE_F00D);
    check_eq("b_tag_p0", bus_b.resp_tag, 11'h008);
    b_cycle(32'h0000_0000, 0, 11'h0, 3'b000, -1, -1, 32'h0, 11'h0);
    check_eq("b_ack_done", bus_b.ack, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
